handshake_kernel_arbiter: RTL and testbench

Shares one in-order, Handshake-lowered kernel (control-token start in, data result out, control-token done out) among `NUM_REQ` requesters. It grants kernel starts round-robin, records each granted requester in a tag FIFO, and joins each result with its done token. Each joined response goes back to the requester that started that invocation. It sits between requester logic (or a bench driver) and the kernel's `arg0`/`arg1`/`arg2` ports.

---
 rtl/handshake_kernel_arbiter.sv | 128 ++++++++++++
 tb/tb_handshake_kernel_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_kernel_arbiter.sv
// Round-robin arbiter that shares one in-order kernel among NUM_REQ requesters.
// Granted requester indices queue in a tag FIFO; each result is joined with its done token and returned to that requester.
module handshake_kernel_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                resp_valid,
  input  logic [NUM_REQ-1:0]                resp_ready,
  output logic [DATA_WIDTH-1:0]             resp_data,
  output logic                              start_valid,
  input  logic                              start_ready,
  input  logic                              result_valid,
  output logic                              result_ready,
  input  logic [DATA_WIDTH-1:0]             result_data,
  input  logic                              done_valid,
  output logic                              done_ready,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight,
  output logic                              proto_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;

  logic [IW-1:0]         r_rr, r_lock_g;
  logic                  r_lock;
  logic [IW-1:0]         r_tag [MAX_INFLIGHT];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_res_full, r_done_full, r_proto_err;
  logic [DATA_WIDTH-1:0] r_res_data;

  logic [IW-1:0] w_cand, w_g, w_head;
  logic          w_any, w_full, w_empty, w_join;
  logic          w_start_fire, w_res_fire, w_done_fire, w_resp_fire;

  // First requester at or after rr; lower offsets overwrite higher ones.
  always_comb begin
    w_cand = r_rr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_rr) + k) % NUM_REQ;
      if (req_valid[idx]) w_cand = IW'(idx);
    end
  end

  assign w_any   = |req_valid;
  assign w_full  = (r_cnt == CW'(MAX_INFLIGHT));
  assign w_empty = (r_cnt == '0);
  assign w_g     = r_lock ? r_lock_g : w_cand;
  assign w_head  = r_tag[r_rptr];
  assign w_join  = r_res_full && r_done_full && !reset;

  assign start_valid  = !reset && w_any && !w_full;
  assign w_start_fire = start_valid && start_ready;
  assign result_ready = !reset && !r_res_full;
  assign done_ready   = !reset && !r_done_full;
  assign w_res_fire   = result_valid && result_ready;
  assign w_done_fire  = done_valid && done_ready;
  assign w_resp_fire  = w_join && resp_ready[w_head];
  assign resp_data    = w_join ? r_res_data : '0;
  assign inflight     = reset ? '0 : r_cnt;
  assign proto_err    = r_proto_err;

  always_comb begin
    req_ready = '0;
    if (w_start_fire) req_ready[w_g] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (w_join) resp_valid[w_head] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (w_start_fire) r_tag[r_wptr] <= w_g;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr        <= '0;
      r_lock      <= 1'b0;
      r_lock_g    <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_res_full  <= 1'b0;
      r_done_full <= 1'b0;
      r_res_data  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      // Freeze the grant while the kernel is stalling the start token.
      if (w_start_fire) begin
        r_lock <= 1'b0;
        r_rr   <= (w_g == IW'(NUM_REQ - 1)) ? '0 : w_g + IW'(1);
        r_wptr <= r_wptr + AW'(1);
      end else if (start_valid) begin
        r_lock   <= 1'b1;
        r_lock_g <= w_g;
      end

      if (w_resp_fire) r_rptr <= r_rptr + AW'(1);

      case ({w_start_fire, w_resp_fire})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      // Tokens with nothing outstanding are swallowed and flagged, never joined.
      if (w_res_fire && !w_empty) begin
        r_res_full <= 1'b1;
        r_res_data <= result_data;
      end else if (w_resp_fire) begin
        r_res_full <= 1'b0;
      end

      if (w_done_fire && !w_empty) r_done_full <= 1'b1;
      else if (w_resp_fire)        r_done_full <= 1'b0;

      if ((w_res_fire || w_done_fire) && w_empty) r_proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_handshake_kernel_arbiter.sv
// Directed bench: stimulus pushes expected responses into a scoreboard queue,
// a negedge monitor pops and compares every response handshake.
module tb_handshake_kernel_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MI = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [DW-1:0] resp_data, result_data;
  logic          start_valid, start_ready, result_valid, result_ready;
  logic          done_valid, done_ready, proto_err;
  logic [$clog2(MI):0] inflight;

  typedef struct { int req; logic [DW-1:0] data; } exp_t;
  exp_t expq[$];
  exp_t m_e;
  int total = 0;
  int bad   = 0;

  handshake_kernel_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_INFLIGHT(MI)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .start_valid(start_valid), .start_ready(start_ready),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .done_valid(done_valid), .done_ready(done_ready),
    .inflight(inflight), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && ((resp_valid & resp_ready) != '0)) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected got valid=%b data=%0d want none", resp_valid, resp_data);
      end else begin
        m_e = expq.pop_front();
        chk("resp_req", 64'(resp_valid), 64'(1) << m_e.req);
        chk("resp_data", 64'(resp_data), 64'(m_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clock); #1;
  endtask

  task automatic push(input int r, input logic [DW-1:0] d);
    exp_t e;
    e.req = r; e.data = d;
    expq.push_back(e);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0; start_ready = 1'b0; result_valid = 1'b0; done_valid = 1'b0;
    result_data = '0; resp_ready = '1;
    cyc; cyc;
    reset = 1'b0;
  endtask

  task automatic issue(input logic [N-1:0] rv, input logic [N-1:0] exp_rdy);
    req_valid = rv; start_ready = 1'b1;
    @(negedge clock);
    chk("grant", 64'(req_ready), 64'(exp_rdy));
    cyc;
  endtask

  task automatic deliver(input logic [DW-1:0] d);
    result_valid = 1'b1; done_valid = 1'b1; result_data = d;
    @(negedge clock);
    chk("join_ready", 64'({result_ready, done_ready}), 64'(2'b11));
    cyc;
    result_valid = 1'b0; done_valid = 1'b0;
    @(negedge clock);
    chk("resp_present", 64'(|resp_valid), 64'(1));
    cyc;
  endtask

  initial begin
    // Reset values with requests and tokens pending
    reset = 1'b1; req_valid = '1; start_ready = 1'b1; result_valid = 1'b1;
    done_valid = 1'b1; result_data = 32'hdead; resp_ready = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_start_valid", 64'(start_valid), 0);
    chk("rst_res_done_ready", 64'({result_ready, done_ready}), 0);
    chk("rst_resp", 64'({resp_valid, resp_data}), 0);
    chk("rst_inflight", 64'(inflight), 0);
    chk("rst_proto_err", 64'(proto_err), 0);

    // Single requester
    do_reset;
    req_valid = 4'b0001; start_ready = 1'b1;
    @(negedge clock);
    chk("t1_req_ready", 64'(req_ready), 64'(4'b0001));
    chk("t1_start_valid", 64'(start_valid), 1);
    push(0, 42);
    cyc;
    req_valid = '0;
    @(negedge clock);
    chk("t1_inflight1", 64'(inflight), 1);
    cyc;
    deliver(42);
    @(negedge clock);
    chk("t1_inflight0", 64'(inflight), 0);
    cyc;

    // Round-robin, two rounds
    do_reset;
    for (int k = 0; k < 4; k++) begin
      push(k, 32'(100 + k));
      issue(4'b1111, 4'(1 << k));
    end
    @(negedge clock);
    chk("t2_full_start", 64'(start_valid), 0);
    chk("t2_full_inflight", 64'(inflight), 4);
    cyc;
    req_valid = '0;
    for (int k = 0; k < 4; k++) deliver(32'(100 + k));
    for (int k = 0; k < 4; k++) begin
      push(k, 32'(104 + k));
      issue(4'b1111, 4'(1 << k));
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) deliver(32'(104 + k));

    // Grant lock
    do_reset;
    push(0, 5);
    issue(4'b0001, 4'b0001);
    req_valid = '0;
    deliver(5);
    start_ready = 1'b0; req_valid = 4'b0100;
    @(negedge clock);
    chk("t3_stalled_start", 64'({start_valid, req_ready}), 64'(5'b10000));
    cyc;
    req_valid = 4'b0110;
    @(negedge clock);
    chk("t3_stalled_rdy", 64'(req_ready), 0);
    cyc;
    push(2, 11);
    issue(4'b0110, 4'b0100);
    push(3, 12);
    issue(4'b1010, 4'b1000);
    push(1, 13);
    issue(4'b0010, 4'b0010);
    req_valid = '0;
    deliver(11); deliver(12); deliver(13);

    // Full and backpressure
    do_reset;
    for (int i = 0; i < 4; i++) begin
      push(0, 32'(20 + i));
      issue(4'b0001, 4'b0001);
    end
    @(negedge clock);
    chk("t4_full", 64'({start_valid, req_ready}), 0);
    chk("t4_inflight4", 64'(inflight), 4);
    cyc;
    resp_ready = '0;
    result_valid = 1'b1; done_valid = 1'b1; result_data = 20;
    cyc;
    result_valid = 1'b0; done_valid = 1'b0;
    @(negedge clock);
    chk("t4_hold_valid", 64'(resp_valid), 64'(4'b0001));
    chk("t4_join_busy", 64'({result_ready, done_ready}), 0);
    cyc;
    @(negedge clock);
    chk("t4_hold_valid2", 64'(resp_valid), 64'(4'b0001));
    cyc;
    resp_ready = '1;
    cyc;
    @(negedge clock);
    chk("t4_reopen", 64'({start_valid, req_ready}), 64'(5'b10001));
    chk("t4_inflight3", 64'(inflight), 3);
    push(0, 24);
    cyc;
    @(negedge clock);
    chk("t4_refull", 64'(start_valid), 0);
    chk("t4_inflight4b", 64'(inflight), 4);
    cyc;
    req_valid = '0;
    for (int i = 21; i <= 24; i++) deliver(32'(i));

    // Out-of-order tokens
    do_reset;
    push(0, 7);
    issue(4'b0011, 4'b0001);
    push(1, 9);
    issue(4'b0011, 4'b0010);
    req_valid = '0;
    done_valid = 1'b1;
    @(negedge clock);
    chk("t5_done_ready", 64'(done_ready), 1);
    cyc;
    done_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("t5_done_blocked", 64'({done_ready, |resp_valid}), 0);
      cyc;
    end
    result_valid = 1'b1; result_data = 7;
    @(negedge clock);
    chk("t5_res_ready", 64'({result_ready, done_ready}), 64'(2'b10));
    cyc;
    result_valid = 1'b0;
    @(negedge clock);
    chk("t5_resp7", 64'(resp_valid), 64'(4'b0001));
    cyc;
    deliver(9);

    // Protocol error, then mid-run reset
    do_reset;
    result_valid = 1'b1; result_data = 55;
    @(negedge clock);
    chk("t6_res_ready", 64'(result_ready), 1);
    cyc;
    result_valid = 1'b0;
    @(negedge clock);
    chk("t6_proto_err", 64'(proto_err), 1);
    chk("t6_no_resp", 64'({resp_valid, resp_data}), 0);
    cyc;
    push(0, 66);
    issue(4'b0001, 4'b0001);
    req_valid = '0;
    done_valid = 1'b1;
    cyc;
    done_valid = 1'b0;
    @(negedge clock);
    chk("t6_not_latched", 64'(resp_valid), 0);
    chk("t6_err_sticky", 64'(proto_err), 1);
    cyc;
    result_valid = 1'b1; result_data = 66;
    cyc;
    result_valid = 1'b0;
    @(negedge clock);
    chk("t6_resp66", 64'(resp_valid), 64'(4'b0001));
    cyc;
    issue(4'b0001, 4'b0001);
    issue(4'b0001, 4'b0001);
    @(negedge clock);
    chk("t6_inflight2", 64'(inflight), 2);
    result_valid = 1'b1; done_valid = 1'b1; result_data = 77;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_req", 64'({start_valid, req_ready}), 0);
    chk("t6_rst_join", 64'({result_ready, done_ready, resp_valid}), 0);
    chk("t6_rst_data", 64'(resp_data), 0);
    chk("t6_rst_inflight", 64'(inflight), 0);
    chk("t6_rst_proto", 64'(proto_err), 0);
    result_valid = 1'b0; done_valid = 1'b0;
    cyc; cyc;
    reset = 1'b0;
    @(negedge clock);
    chk("t6_post_rst", 64'({start_valid, req_ready}), 64'(5'b10001));
    chk("t6_post_inflight", 64'(inflight), 0);
    cyc;
    req_valid = '0;
    chk("sb_empty", 64'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
